mem_arbiter: RTL and testbench

//  Shares the byte-wide single-port on-board RAM between the instruction-fetch port (IF) and the

---
 rtl/mem_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Purpose: shares a byte-wide single-port RAM between the instruction-fetch (IF) and load/store (LS) clients.
// Latency: accept in cycle 0; reads respond in cycle N+2 (IF: 6), writes in cycle N+1 (N = byte count).
// Backpressure: the ready outputs are combinational and only in IDLE with ram_ready; a single access is in flight.
//
// Ports:
//   clk_in, reset                       clock, asynchronous active-high reset
//   ram_ready                           RAM clear sweep complete; sampled only in IDLE
//   ram_en/ram_r_nw/ram_a/ram_wdata     RAM pins; ram_rdata is registered by the RAM (1 cycle)
//   if_valid/if_addr/if_ready           IF 4-byte read request handshake
//   if_resp_valid/if_resp_data          IF response pulse and held word
//   ls_valid/ls_write/ls_size/ls_addr/ls_wdata/ls_ready   LS request handshake
//   ls_resp_valid/ls_resp_data          LS response pulse and held load data (0 for stores)
module mem_arbiter #(
   parameter int ADDR_WIDTH = 17
) (
   input  logic                  clk_in,
   input  logic                  reset,
   input  logic                  ram_ready,
   output logic                  ram_en,
   output logic                  ram_r_nw,
   output logic [ADDR_WIDTH-1:0] ram_a,
   output logic [7:0]            ram_wdata,
   input  logic [7:0]            ram_rdata,
   input  logic                  if_valid,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_ready,
   output logic                  if_resp_valid,
   output logic [31:0]           if_resp_data,
   input  logic                  ls_valid,
   input  logic                  ls_write,
   input  logic [1:0]            ls_size,
   input  logic [ADDR_WIDTH-1:0] ls_addr,
   input  logic [31:0]           ls_wdata,
   output logic                  ls_ready,
   output logic                  ls_resp_valid,
   output logic [31:0]           ls_resp_data
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_LS = 1'b1;

   typedef struct packed {
      logic                  port;
      logic                  write;
      logic [2:0]            nbytes;
      logic [ADDR_WIDTH-1:0] addr;
      logic [31:0]           wdata;
   } req_t;

   state_t                state, state_nxt;
   req_t                  req_q;
   logic [2:0]            cnt;          // index of the byte being issued
   logic                  last_grant;
   logic [31:0]           rd_buf;
   logic [31:0]           rd_next;

   logic                  grant_if, grant_ls;
   logic                  last_byte;
   logic                  cap_vld;
   logic [1:0]            cap_idx;
   logic                  done;
   logic                  en_c, r_nw_c;
   logic [ADDR_WIDTH-1:0] a_c;
   logic [7:0]            wdata_c;

   logic                  if_resp_valid_q, ls_resp_valid_q;
   logic [31:0]           if_resp_data_q, ls_resp_data_q;

   function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
      case (size)
         2'b00:   size_to_nbytes = 3'd1;
         2'b01:   size_to_nbytes = 3'd2;
         default: size_to_nbytes = 3'd4;
      endcase
   endfunction

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant_if  = 1'b0;
      grant_ls  = 1'b0;
      en_c      = 1'b0;
      r_nw_c    = 1'b1;
      a_c       = '0;
      wdata_c   = '0;
      cap_vld   = 1'b0;
      cap_idx   = 2'd0;
      done      = 1'b0;
      last_byte = (cnt == (req_q.nbytes - 3'd1));

      unique case (state)
         IDLE: begin
            if (ram_ready) begin
               if (if_valid && ls_valid) begin
                  // Round-robin: the port not served last time wins.
                  grant_ls = (last_grant == PORT_IF);
                  grant_if = (last_grant == PORT_LS);
               end else begin
                  grant_if = if_valid;
                  grant_ls = ls_valid;
               end
            end
            if (grant_if || grant_ls) state_nxt = ISSUE;
         end
         ISSUE: begin
            en_c   = 1'b1;
            r_nw_c = ~req_q.write;
            a_c    = req_q.addr + ADDR_WIDTH'(cnt);   // wraps at the top of the RAM
            if (req_q.write) begin
               wdata_c = req_q.wdata[{cnt[1:0], 3'b000} +: 8];
            end else if (cnt != 3'd0) begin
               // RAM data lags the address by one cycle: collect the previous byte.
               cap_vld = 1'b1;
               cap_idx = cnt[1:0] - 2'd1;
            end
            if (last_byte) begin
               if (req_q.write) begin
                  state_nxt = IDLE;
                  done      = 1'b1;
               end else begin
                  state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Keep the RAM enabled on the last address so its final byte arrives.
            en_c      = 1'b1;
            r_nw_c    = 1'b1;
            a_c       = req_q.addr + ADDR_WIDTH'(cnt);
            cap_vld   = 1'b1;
            cap_idx   = cnt[1:0];
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Read word including the byte arriving this cycle, so DRAIN can respond directly.
   always_comb begin
      rd_next = rd_buf;
      if (cap_vld) rd_next[{cap_idx, 3'b000} +: 8] = ram_rdata;
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         req_q           <= '0;
         cnt             <= 3'd0;
         last_grant      <= PORT_IF;
         rd_buf          <= '0;
         if_resp_valid_q <= 1'b0;
         ls_resp_valid_q <= 1'b0;
         if_resp_data_q  <= '0;
         ls_resp_data_q  <= '0;
      end else begin
         if_resp_valid_q <= 1'b0;
         ls_resp_valid_q <= 1'b0;

         if (grant_if || grant_ls) begin
            last_grant <= grant_ls ? PORT_LS : PORT_IF;
            cnt        <= 3'd0;
            rd_buf     <= '0;   // unused upper bytes of short loads read as 0
            if (grant_ls) begin
               req_q <= '{port: PORT_LS, write: ls_write, nbytes: size_to_nbytes(ls_size),
                          addr: ls_addr, wdata: ls_wdata};
            end else begin
               req_q <= '{port: PORT_IF, write: 1'b0, nbytes: 3'd4,
                          addr: if_addr, wdata: 32'd0};
            end
         end else begin
            if (state == ISSUE && !last_byte) cnt <= cnt + 3'd1;
            if (cap_vld) rd_buf <= rd_next;
         end

         if (done) begin
            if (req_q.port == PORT_LS) begin
               ls_resp_valid_q <= 1'b1;
               ls_resp_data_q  <= req_q.write ? 32'd0 : rd_next;
            end else begin
               if_resp_valid_q <= 1'b1;
               if_resp_data_q  <= rd_next;
            end
         end
      end
   end

   // Reset forces every output low at once, including the idle-high read strobe.
   assign ram_en        = en_c;
   assign ram_r_nw      = r_nw_c & ~reset;
   assign ram_a         = a_c;
   assign ram_wdata     = wdata_c;
   assign if_ready      = grant_if & ~reset;
   assign ls_ready      = grant_ls & ~reset;
   assign if_resp_valid = if_resp_valid_q;
   assign if_resp_data  = if_resp_data_q;
   assign ls_resp_valid = ls_resp_valid_q;
   assign ls_resp_data  = ls_resp_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: self-checking bench for mem_arbiter with a byte-wide registered-read RAM model.
// Latency: checks response cycle counts against hand-computed values per access size.
// Backpressure: requests are held until the matching ready is seen, bounded by cycle budgets.
module tb_mem_arbiter;

   logic        clk_in;
   logic        reset;
   logic        ram_ready;
   logic        ram_en;
   logic        ram_r_nw;
   logic [16:0] ram_a;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;
   logic        if_valid;
   logic [16:0] if_addr;
   logic        if_ready;
   logic        if_resp_valid;
   logic [31:0] if_resp_data;
   logic        ls_valid;
   logic        ls_write;
   logic [1:0]  ls_size;
   logic [16:0] ls_addr;
   logic [31:0] ls_wdata;
   logic        ls_ready;
   logic        ls_resp_valid;
   logic [31:0] ls_resp_data;

   logic [7:0]  mem [0:(1<<17)-1];

   int n_pass;
   int n_total;

   mem_arbiter #(.ADDR_WIDTH(17)) dut (
      .clk_in(clk_in), .reset(reset), .ram_ready(ram_ready),
      .ram_en(ram_en), .ram_r_nw(ram_r_nw), .ram_a(ram_a),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready),
      .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
      .ls_valid(ls_valid), .ls_write(ls_write), .ls_size(ls_size),
      .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_ready(ls_ready),
      .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // RAM model: contents loaded while reset is high; read data registered one cycle after address.
   always @(posedge clk_in) begin
      if (reset) begin
         ram_rdata     <= 8'h00;
         mem[17'h00000] <= 8'hEE;
         mem[17'h00001] <= 8'h5A;
         mem[17'h00002] <= 8'h6B;
         mem[17'h00010] <= 8'h11;
         mem[17'h00011] <= 8'h22;
         mem[17'h00012] <= 8'h33;
         mem[17'h00013] <= 8'h44;
         mem[17'h00100] <= 8'h80;
         mem[17'h00200] <= 8'hDE;
         mem[17'h00201] <= 8'hAD;
         mem[17'h00202] <= 8'hBE;
         mem[17'h00203] <= 8'hEF;
         mem[17'h00300] <= 8'h00;
         mem[17'h00301] <= 8'h99;
         mem[17'h00302] <= 8'h88;
         mem[17'h00303] <= 8'h77;
         mem[17'h1FFFF] <= 8'hEE;
      end else if (ram_en) begin
         ram_rdata <= mem[ram_a];
         if (!ram_r_nw) mem[ram_a] <= ram_wdata;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_total++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
   endtask

   // Issues one request; returns response data, response cycle (-1 on timeout)
   // and the resp_valid level one cycle after the response.
   task automatic do_req(input bit is_ls, input logic wr, input logic [1:0] sz,
                         input logic [16:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output int lat, output logic tail);
      bit got;
      rd   = '0;
      lat  = -1;
      tail = 1'b0;
      got  = 1'b0;
      if (is_ls) begin
         ls_valid = 1'b1; ls_write = wr; ls_size = sz; ls_addr = a; ls_wdata = wd;
      end else begin
         if_valid = 1'b1; if_addr = a;
      end
      for (int t = 0; t < 50 && !got; t++) begin
         @(negedge clk_in);
         got = is_ls ? ls_ready : if_ready;
         @(posedge clk_in); #1;
      end
      ls_valid = 1'b0;
      if_valid = 1'b0;
      if (!got) return;
      got = 1'b0;
      for (int t = 1; t <= 20 && !got; t++) begin
         @(negedge clk_in);
         if (is_ls ? ls_resp_valid : if_resp_valid) begin
            got = 1'b1;
            lat = t;
            rd  = is_ls ? ls_resp_data : if_resp_data;
         end
         @(posedge clk_in); #1;
      end
      if (got) begin
         @(negedge clk_in);
         tail = is_ls ? ls_resp_valid : if_resp_valid;
         @(posedge clk_in); #1;
      end
   endtask

   typedef struct {
      logic        wr;
      logic [1:0]  sz;
      logic [16:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      int          exp_lat;
   } vec_t;

   vec_t vecs [10];

   initial begin
      logic [31:0] rd;
      int          lat;
      logic        tail;
      int          ng;
      int          en_cnt;
      logic        prev_ls;
      logic        exp_order [4];
      int          seen_resp;

      n_pass  = 0;
      n_total = 0;

      vecs[0] = '{1'b1, 2'b01, 17'h1FFFF, 32'hA5B6C7D8, 32'h00000000, 3};
      vecs[1] = '{1'b0, 2'b10, 17'h1FFFF, 32'h00000000, 32'h6B5AC7D8, 6};
      vecs[2] = '{1'b0, 2'b00, 17'h00100, 32'h00000000, 32'h00000080, 3};
      vecs[3] = '{1'b0, 2'b01, 17'h00200, 32'h00000000, 32'h0000ADDE, 4};
      vecs[4] = '{1'b0, 2'b11, 17'h00200, 32'h00000000, 32'hEFBEADDE, 6};
      vecs[5] = '{1'b1, 2'b00, 17'h00300, 32'h11223344, 32'h00000000, 2};
      vecs[6] = '{1'b0, 2'b10, 17'h00300, 32'h00000000, 32'h77889944, 6};
      vecs[7] = '{1'b1, 2'b10, 17'h00400, 32'hCAFEF00D, 32'h00000000, 5};
      vecs[8] = '{1'b0, 2'b01, 17'h00402, 32'h00000000, 32'h0000CAFE, 4};
      vecs[9] = '{1'b0, 2'b00, 17'h00010, 32'h00000000, 32'h00000011, 3};

      exp_order[0] = 1'b1; exp_order[1] = 1'b0;
      exp_order[2] = 1'b1; exp_order[3] = 1'b0;

      // Reset held with RAM not ready and an IF request pending.
      reset = 1'b1; ram_ready = 1'b0;
      if_valid = 1'b1; if_addr = 17'h00010;
      ls_valid = 1'b0; ls_write = 1'b0; ls_size = 2'b00; ls_addr = '0; ls_wdata = '0;
      #2;
      chk("rst_ram_en", ram_en, 0);
      chk("rst_ram_r_nw", ram_r_nw, 0);
      chk("rst_ram_a", ram_a, 0);
      chk("rst_if_ready", if_ready, 0);
      chk("rst_if_resp_valid", if_resp_valid, 0);
      chk("rst_ls_resp_data", ls_resp_data, 0);
      @(posedge clk_in); #1;
      @(negedge clk_in); reset = 1'b0;
      @(posedge clk_in); #1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_in);
         chk($sformatf("s1_wait%0d_if_ready", c), if_ready, 0);
         chk($sformatf("s1_wait%0d_ram_en", c), ram_en, 0);
         @(posedge clk_in); #1;
      end
      ram_ready = 1'b1;
      @(negedge clk_in);
      chk("s1_grant", if_ready, 1);
      chk("s1_idle_r_nw", ram_r_nw, 1);

      // IF read of 0x10 traced cycle by cycle from the accept.
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk_in); #1;
         if (k == 1) if_valid = 1'b0;
         @(negedge clk_in);
         if (k <= 4) begin
            chk($sformatf("s2_c%0d_en", k), ram_en, 1);
            chk($sformatf("s2_c%0d_addr", k), ram_a, 17'h00010 + 17'(k - 1));
            chk($sformatf("s2_c%0d_r_nw", k), ram_r_nw, 1);
         end else if (k == 5) begin
            chk("s2_drain_en", ram_en, 1);
            chk("s2_drain_addr", ram_a, 17'h00013);
         end else begin
            chk($sformatf("s2_c%0d_en", k), ram_en, 0);
         end
         chk($sformatf("s2_c%0d_resp_valid", k), if_resp_valid, (k == 6) ? 1 : 0);
         if (k == 6) chk("s2_resp_data", if_resp_data, 32'h44332211);
      end
      chk("s2_data_held", if_resp_data, 32'h44332211);
      @(posedge clk_in); #1;

      // Table of LS accesses applied in order.
      foreach (vecs[i]) begin
         do_req(1'b1, vecs[i].wr, vecs[i].sz, vecs[i].addr, vecs[i].wd, rd, lat, tail);
         chk($sformatf("vec%0d_data", i), rd, vecs[i].exp_rd);
         chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      end
      chk("s3_mem_1ffff", mem[17'h1FFFF], 32'hD8);
      chk("s3_mem_00000", mem[17'h00000], 32'hC7);
      chk("s3_mem_00001", mem[17'h00001], 32'h5A);
      chk("s3_mem_00403", mem[17'h00403], 32'hCA);

      // Both ports requesting continuously after a reset.
      reset = 1'b1;
      @(negedge clk_in); reset = 1'b0;
      @(posedge clk_in); #1;
      if_valid = 1'b1; if_addr = 17'h00010;
      ls_valid = 1'b1; ls_write = 1'b0; ls_size = 2'b00; ls_addr = 17'h00100;
      ng = 0; en_cnt = 0; prev_ls = 1'b0;
      for (int c = 0; c < 100 && ng < 4; c++) begin
         @(negedge clk_in);
         if (ram_en) en_cnt++;
         if (if_ready || ls_ready) begin
            chk($sformatf("s4_g%0d_one_ready", ng), if_ready & ls_ready, 0);
            chk($sformatf("s4_g%0d_en_idle", ng), ram_en, 0);
            if (ng > 0) chk($sformatf("s4_g%0d_burst", ng), en_cnt, prev_ls ? 2 : 5);
            chk($sformatf("s4_g%0d_is_ls", ng), ls_ready, exp_order[ng]);
            prev_ls = ls_ready;
            ng++;
            en_cnt = 0;
         end
         @(posedge clk_in); #1;
      end
      chk("s4_grant_count", ng, 4);
      if_valid = 1'b0;
      ls_valid = 1'b0;
      repeat (10) @(posedge clk_in);
      #1;

      // Reset during the second issued byte of an IF read.
      if_valid = 1'b1; if_addr = 17'h00010;
      @(negedge clk_in);
      chk("s6_accept", if_ready, 1);
      @(posedge clk_in); #1;
      if_valid = 1'b0;
      @(posedge clk_in); #1;
      @(negedge clk_in);
      chk("s6_byte2_en", ram_en, 1);
      chk("s6_byte2_addr", ram_a, 17'h00011);
      reset = 1'b1; ram_ready = 1'b0;
      #1;
      chk("s6_abort_en", ram_en, 0);
      chk("s6_abort_r_nw", ram_r_nw, 0);
      chk("s6_abort_addr", ram_a, 0);
      chk("s6_abort_resp_data", if_resp_data, 0);
      repeat (2) @(posedge clk_in);
      @(negedge clk_in); reset = 1'b0;
      seen_resp = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk_in);
         if (if_resp_valid || ram_en) seen_resp++;
      end
      chk("s6_no_resp_after_abort", seen_resp, 0);
      @(posedge clk_in); #1;
      ram_ready = 1'b1;
      do_req(1'b0, 1'b0, 2'b10, 17'h00010, 32'h0, rd, lat, tail);
      chk("s6_repeat_data", rd, 32'h44332211);
      chk("s6_repeat_latency", lat, 6);
      chk("s6_repeat_pulse", tail, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
